led_mode_sequencer: RTL and testbench

Board-level controller that drives the green LED bank. It sequences blink and chase patterns at a switch-selectable rate and steps through display modes on a pushbutton. It replaces free-running single-LED blinking with one scheduler that owns LEDG. It sits directly between the board pins (CLOCK_50, KEY, SW) and LEDG, with no other logic in between.

---
 rtl/led_pkg.sv | 29 ++
 rtl/tick_gen.sv | 37 +++
 rtl/led_mode_sequencer.sv | 141 ++++++++++++++
 tb/tb_led_mode_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
// Shared types and constants for the LED mode sequencer and its tick divider.
//   mode_t      : display mode encoding (2 bits), also driven on MODE
//   RATE_W      : width of the step-rate select (step = 2^rate base ticks)
//   RATE_CNT_W  : width of the rate counter, sized for the longest period
//   BASE_DIV_W  : divider width for the default board divider
//   div_width() : divider counter width for an arbitrary DIV
// ----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    localparam int RATE_W           = 2;
    // Longest period is 2^(2^RATE_W - 1) ticks, so the count needs 2^RATE_W - 1 bits.
    localparam int RATE_CNT_W       = (1 << RATE_W) - 1;
    localparam int BASE_DIV_DEFAULT = 2_500_000;
    localparam int BASE_DIV_W       = $clog2(BASE_DIV_DEFAULT);

    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Free-running divider producing a registered one-cycle pulse every DIV
// cycles. The pulse is high in the cycle after the counter reaches DIV-1.
//   CLOCK_50 : clock
//   RESET    : synchronous active-high reset
//   tick     : one-cycle pulse, period DIV cycles
// ----------------------------------------------------------------------------
module tick_gen
    import led_pkg::*;
#(
    parameter int DIV = BASE_DIV_DEFAULT
) (
    input  logic CLOCK_50,
    input  logic RESET,
    output logic tick
);

    localparam int W = div_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;
    logic         r_tick;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == LAST);
            r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/led_mode_sequencer.sv
// ----------------------------------------------------------------------------
// led_mode_sequencer
// Owns the green LED bank: steps blink/chase/bounce patterns at a
// switch-selected rate and advances the display mode on each button press.
//   CLOCK_50 : board clock
//   RESET    : synchronous active-high reset
//   KEY_NEXT : mode pushbutton, active-low, asynchronous and bouncing
//   SW_EN    : 1 = run, 0 = freeze pattern and rate counter
//   SW_RATE  : step period = 2^SW_RATE base ticks
//   LEDG     : registered LED pattern
//   MODE     : registered current mode
//
// state       | meaning
// MODE_OFF    | all LEDs dark
// MODE_BLINK  | whole bank toggles each step
// MODE_CHASE  | single lit LED rotates toward the MSB
// MODE_BOUNCE | single lit LED walks MSB-ward then back, one dwell per end
// ----------------------------------------------------------------------------
module led_mode_sequencer
    import led_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BASE_DIV = 2_500_000,
    parameter int N_LEDS   = 8
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              KEY_NEXT,
    input  logic              SW_EN,
    input  logic [RATE_W-1:0] SW_RATE,
    output logic [N_LEDS-1:0] LEDG,
    output logic [1:0]        MODE
);

    logic                  w_tick;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_key_prev;
    mode_t                 r_mode;
    logic [N_LEDS-1:0]     r_pattern;
    logic                  r_dir_up;
    logic [RATE_CNT_W-1:0] r_rate_cnt;

    logic                  w_press;
    logic                  w_rate_hit;
    logic [RATE_CNT_W-1:0] w_thresh;
    mode_t                 w_next_mode;
    logic [N_LEDS-1:0]     w_load_pat;
    logic [N_LEDS-1:0]     w_step_pat;
    logic                  w_step_up;

    tick_gen #(.DIV(BASE_DIV)) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .tick     (w_tick)
    );

    // Sampling the synchronized key only on ticks acts as the debouncer.
    assign w_press     = w_tick & ~r_sync2 & r_key_prev;
    assign w_thresh    = ~({RATE_CNT_W{1'b1}} << SW_RATE);
    // >= so that lowering the rate mid-period steps on the next tick.
    assign w_rate_hit  = (r_rate_cnt >= w_thresh);
    assign w_next_mode = mode_t'(r_mode + 2'd1);

    always_comb begin
        w_load_pat = '0;
        case (w_next_mode)
            MODE_BLINK:  w_load_pat = '1;
            MODE_CHASE,
            MODE_BOUNCE: w_load_pat[0] = 1'b1;
            default:     w_load_pat = '0;
        endcase
    end

    // Bounce flips direction while sitting on an end LED, so each end is lit
    // for exactly one step period.
    always_comb begin
        w_step_pat = r_pattern;
        w_step_up  = r_dir_up;
        case (r_mode)
            MODE_OFF:   w_step_pat = '0;
            MODE_BLINK: w_step_pat = ~r_pattern;
            MODE_CHASE: w_step_pat = {r_pattern[N_LEDS-2:0], r_pattern[N_LEDS-1]};
            MODE_BOUNCE: begin
                if (r_dir_up) begin
                    if (r_pattern[N_LEDS-1]) begin
                        w_step_up  = 1'b0;
                        w_step_pat = r_pattern >> 1;
                    end else begin
                        w_step_pat = r_pattern << 1;
                    end
                end else begin
                    if (r_pattern[0]) begin
                        w_step_up  = 1'b1;
                        w_step_pat = r_pattern << 1;
                    end else begin
                        w_step_pat = r_pattern >> 1;
                    end
                end
            end
            default: w_step_pat = r_pattern;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_key_prev <= 1'b1;
            r_mode     <= MODE_OFF;
            r_pattern  <= '0;
            r_dir_up   <= 1'b1;
            r_rate_cnt <= '0;
        end else begin
            r_sync1 <= KEY_NEXT;
            r_sync2 <= r_sync1;
            if (w_tick) begin
                r_key_prev <= r_sync2;
            end
            // A press on the same tick as a step wins; the step is dropped.
            if (w_press) begin
                r_mode     <= w_next_mode;
                r_pattern  <= w_load_pat;
                r_dir_up   <= 1'b1;
                r_rate_cnt <= '0;
            end else if (w_tick && SW_EN) begin
                if (w_rate_hit) begin
                    r_rate_cnt <= '0;
                    r_pattern  <= w_step_pat;
                    r_dir_up   <= w_step_up;
                end else begin
                    r_rate_cnt <= r_rate_cnt + 1'b1;
                end
            end
        end
    end

    assign LEDG = r_pattern;
    assign MODE = r_mode;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// ----------------------------------------------------------------------------
// tb_led_mode_sequencer
// Self-checking bench for led_mode_sequencer with BASE_DIV=4, N_LEDS=8.
// Edge numbering: E1 is the first rising edge with RESET low; base ticks
// take effect on edges E5, E9, E13, ... Each vector drives inputs, runs up to
// an absolute edge number and checks MODE/LEDG at the following falling edge.
// ----------------------------------------------------------------------------
module tb_led_mode_sequencer;

    logic       clk;
    logic       rst;
    logic       key;
    logic       en;
    logic [1:0] rate;
    logic [7:0] ledg;
    logic [1:0] mode;

    int checks   = 0;
    int failures = 0;
    int ecount   = 0;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] led;
    } exp_t;

    typedef struct {
        int         upto;
        logic       key;
        logic       en;
        logic [1:0] rate;
        logic [1:0] mode;
        logic [7:0] led;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    led_mode_sequencer #(
        .CLK_HZ   (50_000_000),
        .BASE_DIV (4),
        .N_LEDS   (8)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .KEY_NEXT (key),
        .SW_EN    (en),
        .SW_RATE  (rate),
        .LEDG     (ledg),
        .MODE     (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) ecount <= ecount + 1;
    end

    task automatic add(input int upto, input logic k, input logic e, input logic [1:0] r,
                       input logic [1:0] m, input logic [7:0] l);
        vec_t v;
        v.upto = upto; v.key = k; v.en = e; v.rate = r; v.mode = m; v.led = l;
        vecs.push_back(v);
    endtask

    task automatic compare_out(input string name);
        exp_t x;
        x = sb_q.pop_front();
        checks++;
        if ({mode, ledg} !== {x.mode, x.led}) begin
            failures++;
            $display("FAIL %s: got mode=%0d ledg=%h, want mode=%0d ledg=%h",
                     name, mode, ledg, x.mode, x.led);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int guard;
        key  = v.key;
        en   = v.en;
        rate = v.rate;
        sb_q.push_back({v.mode, v.led});
        guard = 0;
        while (ecount < v.upto && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (ecount != v.upto) begin
            checks++;
            failures++;
            $display("FAIL vec%0d_timing: edge=%0d, want edge=%0d", idx, ecount, v.upto);
            void'(sb_q.pop_front());
        end else begin
            compare_out($sformatf("vec%0d", idx));
        end
    endtask

    initial begin
        //   upto key en rate mode led
        // idle
        add( 50, 1, 1, 0, 0, 8'h00);
        add(100, 1, 1, 0, 0, 8'h00);
        // press held 40 cycles -> BLINK, toggle every 4 cycles, release inert
        add(104, 0, 1, 0, 0, 8'h00);
        add(105, 0, 1, 0, 1, 8'hFF);
        add(108, 0, 1, 0, 1, 8'hFF);
        add(109, 0, 1, 0, 1, 8'h00);
        add(113, 0, 1, 0, 1, 8'hFF);
        add(140, 0, 1, 0, 1, 8'hFF);
        add(150, 1, 1, 0, 1, 8'h00);
        // CHASE at rate 1: one step per 8 cycles
        add(152, 0, 1, 1, 1, 8'h00);
        add(153, 0, 1, 1, 2, 8'h01);
        add(160, 0, 1, 1, 2, 8'h01);
        add(161, 1, 1, 1, 2, 8'h02);
        add(168, 1, 1, 1, 2, 8'h02);
        add(169, 1, 1, 1, 2, 8'h04);
        add(209, 1, 1, 1, 2, 8'h80);
        add(217, 1, 1, 1, 2, 8'h01);
        // freeze mid-period, resume after remaining count
        add(221, 1, 1, 1, 2, 8'h01);
        add(271, 1, 0, 1, 2, 8'h01);
        add(272, 1, 1, 1, 2, 8'h01);
        add(273, 1, 1, 1, 2, 8'h02);
        // press while frozen loads BOUNCE
        add(276, 0, 0, 0, 2, 8'h02);
        add(277, 0, 0, 0, 3, 8'h01);
        add(280, 0, 0, 0, 3, 8'h01);
        add(290, 1, 0, 0, 3, 8'h01);
        // BOUNCE at rate 0, single dwell at each end
        add(292, 1, 1, 0, 3, 8'h01);
        add(293, 1, 1, 0, 3, 8'h02);
        add(316, 1, 1, 0, 3, 8'h40);
        add(317, 1, 1, 0, 3, 8'h80);
        add(320, 1, 1, 0, 3, 8'h80);
        add(321, 1, 1, 0, 3, 8'h40);
        add(344, 1, 1, 0, 3, 8'h02);
        add(345, 1, 1, 0, 3, 8'h01);
        add(348, 1, 1, 0, 3, 8'h01);
        add(349, 1, 1, 0, 3, 8'h02);
        // presses landing on step ticks: step discarded
        add(352, 0, 1, 0, 3, 8'h02);
        add(353, 0, 1, 0, 0, 8'h00);
        add(357, 1, 1, 0, 0, 8'h00);
        add(360, 0, 1, 0, 0, 8'h00);
        add(361, 0, 1, 0, 1, 8'hFF);
        add(365, 0, 1, 0, 1, 8'h00);
        add(369, 1, 1, 0, 1, 8'hFF);

        rst  = 1'b1;
        key  = 1'b1;
        en   = 1'b1;
        rate = 2'd0;
        repeat (3) @(negedge clk);
        sb_q.push_back({2'd0, 8'h00});
        compare_out("reset_state");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i], i);
        end

        // Reset mid-pattern with LEDs lit takes effect on the next edge.
        rst = 1'b1;
        sb_q.push_back({2'd0, 8'h00});
        @(negedge clk);
        compare_out("reset_mid_pattern");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        key = 1'b1;
        sb_q.push_back({2'd0, 8'h00});
        repeat (20) @(negedge clk);
        compare_out("post_reset_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: time=%0t, want finish before 200000", $time);
        $fatal(1, "timeout");
    end

endmodule
